// File: rtl/rs232_pkg.sv
// Shared types and helpers for the TinyComp RS232 FIFO port.
package rs232_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  localparam int unsigned MAX_DATA_BITS = 8;

  // Rounded bit period in clock cycles.
  function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through head and occupancy count.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LOG2  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [LOG2:0]    count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned DEPTH = 2 ** LOG2;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [LOG2-1:0]  wr_ptr_q;
  logic [LOG2-1:0]  rd_ptr_q;
  logic [LOG2:0]    count_q;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (count_q == '0);
  // count never exceeds DEPTH, so the MSB alone marks full
  assign full    = count_q[LOG2];
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign count   = count_q;
  assign dout    = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/rs232_fifo_port.sv
// Full-duplex UART for TinyComp I/O devices 0/1 with RX and TX FIFOs,
// legacy CPU handshake, sticky overrun / framing-error status.
module rs232_fifo_port
  import rs232_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 40000000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned FIFO_LOG2 = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               RxD,
  output logic               TxD,
  input  logic               readRX,
  output logic               charReady,
  output logic [7:0]         RXchar,
  input  logic               writeTX,
  input  logic [7:0]         TXchar,
  output logic               TXempty,
  output logic [FIFO_LOG2:0] rxCount,
  output logic [FIFO_LOG2:0] txCount,
  output logic               rxOverrun,
  output logic               rxFrameErr,
  input  logic               clearErr
);

  localparam int unsigned DIV = baud_div(CLK_HZ, BAUD);
  localparam int unsigned CW  = $clog2(DIV) + 1;
  localparam int unsigned BW  = $clog2(MAX_DATA_BITS);

  localparam logic [CW-1:0] BIT_RELOAD  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_RELOAD = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [BW-1:0] LAST_BIT    = BW'(DATA_BITS - 1);

  // ---------------- TX path ----------------
  logic [DATA_BITS-1:0] tx_dout;
  logic                 tx_full;
  logic                 tx_empty;
  logic                 tx_pop;

  uart_state_t          tx_state_q, tx_state_d;
  logic [CW-1:0]        tx_cnt_q,   tx_cnt_d;
  logic [BW-1:0]        tx_bit_q,   tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 txd_q,      txd_d;

  sync_fifo #(.WIDTH(DATA_BITS), .LOG2(FIFO_LOG2)) u_tx_fifo (
    .clk   (clock),
    .rst_n (reset),
    .push  (writeTX),
    .pop   (tx_pop),
    .din   (TXchar[DATA_BITS-1:0]),
    .dout  (tx_dout),
    .count (txCount),
    .full  (tx_full),
    .empty (tx_empty)
  );

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_pop     = 1'b0;
    unique case (tx_state_q)
      IDLE: begin
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_dout;
          tx_cnt_d   = BIT_RELOAD;
          tx_state_d = START;
        end
      end
      START: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d   = BIT_RELOAD;
          tx_bit_d   = '0;
          tx_state_d = DATA;
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_ONE;
        end
      end
      DATA: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d   = BIT_RELOAD;
          tx_shift_d = tx_shift_q >> 1;
          if (tx_bit_q == LAST_BIT) tx_state_d = STOP;
          else                      tx_bit_d   = tx_bit_q + 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_ONE;
        end
      end
      STOP: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d = BIT_RELOAD;
          // chain straight into the next start bit when more data is queued
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_dout;
            tx_state_d = START;
          end else begin
            tx_state_d = IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_ONE;
        end
      end
      default: tx_state_d = IDLE;
    endcase
  end

  // TxD is registered one cycle behind the state so each bit spans exactly DIV cycles
  always_comb begin
    txd_d = 1'b1;
    unique case (tx_state_q)
      START:   txd_d = 1'b0;
      DATA:    txd_d = tx_shift_q[0];
      default: txd_d = 1'b1;
    endcase
  end

  // ---------------- RX path ----------------
  logic                 rx_s1_q, rx_s2_q, rx_prev_q;
  uart_state_t          rx_state_q, rx_state_d;
  logic [CW-1:0]        rx_cnt_q,   rx_cnt_d;
  logic [BW-1:0]        rx_bit_q,   rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 ovr_q, ovr_d;
  logic                 fe_q,  fe_d;
  logic                 rx_push;
  logic                 ovr_set;
  logic                 fe_set;
  logic [DATA_BITS-1:0] rx_dout;
  logic                 rx_full;
  logic                 rx_empty;

  sync_fifo #(.WIDTH(DATA_BITS), .LOG2(FIFO_LOG2)) u_rx_fifo (
    .clk   (clock),
    .rst_n (reset),
    .push  (rx_push),
    .pop   (readRX),
    .din   (rx_shift_q),
    .dout  (rx_dout),
    .count (rxCount),
    .full  (rx_full),
    .empty (rx_empty)
  );

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push    = 1'b0;
    ovr_set    = 1'b0;
    fe_set     = 1'b0;
    unique case (rx_state_q)
      IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_cnt_d   = HALF_RELOAD;
          rx_state_d = START;
        end
      end
      START: begin
        if (rx_cnt_q == '0) begin
          rx_cnt_d = BIT_RELOAD;
          rx_bit_d = '0;
          if (rx_s2_q) rx_state_d = IDLE;
          else         rx_state_d = DATA;
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_ONE;
        end
      end
      DATA: begin
        if (rx_cnt_q == '0) begin
          rx_cnt_d   = BIT_RELOAD;
          rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
          if (rx_bit_q == LAST_BIT) rx_state_d = STOP;
          else                      rx_bit_d   = rx_bit_q + 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_ONE;
        end
      end
      STOP: begin
        if (rx_cnt_q == '0) begin
          rx_cnt_d   = BIT_RELOAD;
          rx_state_d = IDLE;
          if (rx_s2_q) begin
            rx_push = 1'b1;
            // a full FIFO still has room if the CPU pops this cycle
            ovr_set = rx_full && !readRX;
          end else begin
            fe_set = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_ONE;
        end
      end
      default: rx_state_d = IDLE;
    endcase
  end

  always_comb begin
    ovr_d = ovr_set ? 1'b1 : (clearErr ? 1'b0 : ovr_q);
    fe_d  = fe_set  ? 1'b1 : (clearErr ? 1'b0 : fe_q);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_state_q <= IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      ovr_q      <= 1'b0;
      fe_q       <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
      rx_s1_q    <= RxD;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      ovr_q      <= ovr_d;
      fe_q       <= fe_d;
    end
  end

  always_comb begin
    RXchar                = '0;
    RXchar[DATA_BITS-1:0] = rx_dout;
  end

  assign TxD        = txd_q;
  assign charReady  = !rx_empty;
  assign TXempty    = !tx_full;
  assign rxOverrun  = ovr_q;
  assign rxFrameErr = fe_q;

endmodule
